// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for pipe_stage_skid.
// slave : the stage itself (accepts in_*, produces out_*).
// master: the surrounding pipeline / testbench side.
interface pipe_stage_skid_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline stage register with valid/ready handshake,
// 2-entry skid buffer, flush and occupancy report.
// Optional statistics counters enabled by defining macro PIPE_STATS_EN;
// without it stall_cnt/bubble_cnt are tied to zero and no counter flops exist.
module pipe_stage_skid #(
    parameter int unsigned WIDTH     = 32,
    parameter logic [31:0] NOP_VALUE = 32'h0000_0033,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    pipe_stage_skid_if.slave      bus,
    output logic [1:0]            occupancy,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      bubble_cnt
);
    localparam logic [WIDTH-1:0] NOP = WIDTH'(NOP_VALUE);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [1:0]       occ_q;
    logic             accept;

    assign accept        = bus.in_valid & in_ready_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;
    assign occupancy     = occ_q;

    // State, storage and registered handshake outputs; reset/flush dominate.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state       <= EMPTY;
            main_q      <= NOP;
            skid_q      <= NOP;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state       <= FULL;
                        main_q      <= bus.in_data;
                        out_valid_q <= 1'b1;
                        occ_q       <= 2'd1;
                    end
                end
                FULL: begin
                    if (accept && bus.out_ready) begin
                        main_q <= bus.in_data;
                    end else if (accept) begin
                        state      <= SKID;
                        skid_q     <= bus.in_data;
                        in_ready_q <= 1'b0;
                        occ_q      <= 2'd2;
                    end else if (bus.out_ready) begin
                        state       <= EMPTY;
                        main_q      <= NOP;
                        out_valid_q <= 1'b0;
                        occ_q       <= 2'd0;
                    end
                end
                SKID: begin
                    if (bus.out_ready) begin
                        state      <= FULL;
                        main_q     <= skid_q;
                        skid_q     <= NOP;
                        in_ready_q <= 1'b1;
                        occ_q      <= 2'd1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    main_q      <= NOP;
                    skid_q      <= NOP;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    occ_q       <= 2'd0;
                end
            endcase
        end
    end

`ifdef PIPE_STATS_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] bubble_q;

    // Saturating stall/bubble counters; cleared by rst only, flush keeps them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (out_valid_q && !bus.out_ready && stall_q != '1) begin
                stall_q <= stall_q + 1'b1;
            end
            if (!out_valid_q && bubble_q != '1) begin
                bubble_q <= bubble_q + 1'b1;
            end
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif
endmodule
